fetch_queue_unit: RTL and testbench

Parametrised successor to the single-cycle fetch stage. Holds the PC and issues requests to a variable-latency instruction memory through a req/ack handshake. Buffers fetched instructions, with their next-PC values, in a DEPTH-entry queue feeding decode through a valid/ready handshake. Adds three things the old stage lacks: redirect (branch/jump) with flush of the queue and stale responses, a halt stop, and back-pressure.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/cla_16b.sv | 35 +++
 rtl/fetch_fifo.sv | 59 +++++
 rtl/fetch_queue_unit.sv | 128 ++++++++++++
 tb/tb_fetch_queue_unit.sv | 395 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default parameters for the prefetching fetch unit.
package fetch_pkg;

   localparam int unsigned      DEF_W        = 16;
   localparam int unsigned      DEF_DEPTH    = 4;
   localparam int unsigned      DEF_INC      = 2;
   localparam logic [DEF_W-1:0] DEF_RESET_PC = '0;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      DROP   = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [DEF_W-1:0] instr;
      logic [DEF_W-1:0] pc_next;
   } fetch_entry_t;

endpackage

// File: rtl/cla_16b.sv
// 16-bit carry-lookahead adder built from four 4-bit lookahead groups.
module cla_16b (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum
);

   logic [15:0] g;
   logic [15:0] p;
   logic [16:0] c;
   logic        gg;
   logic        pg;

   always_comb begin
      g    = a & b;
      p    = a ^ b;
      c    = '0;
      gg   = 1'b0;
      pg   = 1'b0;
      c[0] = cin;
      for (int k = 0; k < 4; k++) begin
         gg = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1]) |
              (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         pg = &p[4*k +: 4];
         for (int i = 0; i < 3; i++) begin
            c[4*k+i+1] = g[4*k+i] | (p[4*k+i] & c[4*k+i]);
         end
         // Group carry-out comes from the lookahead terms, not the ripple chain.
         c[4*k+4] = gg | (pg & c[4*k]);
      end
      sum = p ^ c[15:0];
   end

endmodule

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer of fetch entries with synchronous flush.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH   = DEF_DEPTH,
   parameter type         entry_t = fetch_entry_t
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  entry_t                 wdata,
   output entry_t                 rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   entry_t          mem_q [DEPTH];
   logic [AW-1:0]   rd_ptr_q;
   logic [AW-1:0]   wr_ptr_q;
   logic [CW-1:0]   count_q;
   logic            do_push;
   logic            do_pop;

   always_comb begin
      full    = (count_q == CW'(DEPTH));
      empty   = (count_q == '0);
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      rdata   = mem_q[rd_ptr_q];
      count   = count_q;
   end

   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst && !flush && do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage: PC, req/ack instruction fetch, prefetch queue toward decode,
// redirect with stale-response drop, and halt.
module fetch_queue_unit
   import fetch_pkg::*;
#(
   parameter int unsigned  W        = DEF_W,
   parameter int unsigned  DEPTH    = DEF_DEPTH,
   parameter int unsigned  INC      = DEF_INC,
   parameter logic [W-1:0] RESET_PC = W'(DEF_RESET_PC)
) (
   input  logic         clk,
   input  logic         rst,
   output logic         imem_req,
   output logic [W-1:0] imem_addr,
   input  logic         imem_ack,
   input  logic [W-1:0] imem_rdata,
   input  logic         redirect_valid,
   input  logic [W-1:0] redirect_addr,
   input  logic         halt,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_instr,
   output logic [W-1:0] out_pc_next,
   output logic         busy
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [W-1:0] instr;
      logic [W-1:0] pc_next;
   } entry_t;

   fetch_state_t  state_q;
   logic [W-1:0]  pc_q;
   logic [W-1:0]  pc_inc;
   logic          outstanding_q;
   logic          fifo_push;
   logic          fifo_pop;
   logic          fifo_flush;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   entry_t        fifo_wdata;
   entry_t        fifo_rdata;

   if (W == 16) begin : g_cla
      cla_16b u_pc_add (
         .a   (pc_q),
         .b   (W'(INC)),
         .cin (1'b0),
         .sum (pc_inc)
      );
   end else begin : g_add
      assign pc_inc = pc_q + W'(INC);
   end

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .flush (fifo_flush),
      .wdata (fifo_wdata),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      // An outstanding request already holds a queue slot, so it keeps req high.
      imem_req           = rst && (state_q == FETCH) && (outstanding_q || !fifo_full);
      imem_addr          = pc_q;
      out_valid          = rst && !fifo_empty;
      out_instr          = fifo_rdata.instr;
      out_pc_next        = fifo_rdata.pc_next;
      busy               = rst && (outstanding_q || imem_req || (fifo_count != '0));
      fifo_flush         = redirect_valid && !halt && (state_q != HALTED);
      fifo_push          = imem_req && imem_ack && !halt && !redirect_valid;
      fifo_pop           = out_valid && out_ready && !fifo_flush;
      fifo_wdata.instr   = imem_rdata;
      fifo_wdata.pc_next = pc_inc;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= FETCH;
         pc_q          <= RESET_PC;
         outstanding_q <= 1'b0;
      end else begin
         unique case (state_q)
            FETCH: begin
               if (halt) begin
                  state_q       <= HALTED;
                  outstanding_q <= imem_req && !imem_ack;
               end else if (redirect_valid) begin
                  pc_q          <= redirect_addr;
                  outstanding_q <= imem_req && !imem_ack;
                  if (imem_req && !imem_ack) state_q <= DROP;
               end else if (imem_req && imem_ack) begin
                  pc_q          <= pc_inc;
                  outstanding_q <= 1'b0;
               end else begin
                  outstanding_q <= imem_req;
               end
            end
            DROP: begin
               if (imem_ack) outstanding_q <= 1'b0;
               if (halt) begin
                  state_q <= HALTED;
               end else begin
                  if (redirect_valid) pc_q <= redirect_addr;
                  if (imem_ack) state_q <= FETCH;
               end
            end
            HALTED: begin
               if (imem_ack) outstanding_q <= 1'b0;
            end
            default: state_q <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed scenarios plus randomized traffic against a queue model.
module tb_fetch_queue_unit;

   localparam int unsigned W        = 16;
   localparam int unsigned DEPTH    = 4;
   localparam int unsigned INC      = 2;
   localparam logic [15:0] RESET_PC = 16'h0000;
   localparam int M_FETCH = 0;
   localparam int M_DROP  = 1;
   localparam int M_HALT  = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, imem_req, imem_ack, redirect_valid, halt, out_valid, out_ready, busy;
   logic [15:0] imem_addr, imem_rdata, redirect_addr, out_instr, out_pc_next;

   fetch_queue_unit #(
      .W        (W),
      .DEPTH    (DEPTH),
      .INC      (INC),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .halt           (halt),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc_next    (out_pc_next),
      .busy           (busy)
   );

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc_next;
   } ent_t;

   int n_checks = 0;
   int n_errors = 0;

   // Memory responder: latches the address on a new request, acks after mem_lat cycles.
   int          mem_lat;
   bit          mem_busy;
   int          mem_cnt;
   logic [15:0] mem_addr, mem_key;

   // Reference model.
   ent_t        m_q[$];
   logic [15:0] m_pc;
   int          m_mode;
   bit          m_pend;
   bit          exp_req, exp_valid, exp_busy;
   ent_t        exp_head;

   task automatic prep();
      #1;
      if (!rst) mem_busy = 1'b0;
      else if (!mem_busy && imem_req) begin
         mem_busy = 1'b1;
         mem_cnt  = 0;
         mem_addr = imem_addr;
      end
      imem_ack   = mem_busy && (mem_cnt + 1 >= mem_lat);
      imem_rdata = imem_ack ? (mem_addr ^ mem_key) : 16'($urandom);
      exp_req    = rst && (m_mode == M_FETCH) && (m_pend || m_q.size() < int'(DEPTH));
      exp_valid  = rst && (m_q.size() != 0);
      exp_head   = (m_q.size() != 0) ? m_q[0] : ent_t'('0);
      exp_busy   = rst && (m_pend || exp_req || (m_q.size() != 0));
      #1;
   endtask

   task automatic adv();
      bit          pop;
      logic [15:0] nxt;
      @(posedge clk);
      pop = out_ready && (m_q.size() != 0);
      nxt = m_pc + 16'(INC);
      if (!rst) begin
         m_q.delete();
         m_pc   = RESET_PC;
         m_mode = M_FETCH;
         m_pend = 1'b0;
      end else begin
         case (m_mode)
            M_FETCH: begin
               if (halt) begin
                  m_mode = M_HALT;
                  m_pend = exp_req && !imem_ack;
                  if (pop) void'(m_q.pop_front());
               end else if (redirect_valid) begin
                  m_q.delete();
                  m_pc   = redirect_addr;
                  m_pend = exp_req && !imem_ack;
                  if (m_pend) m_mode = M_DROP;
               end else begin
                  if (pop) void'(m_q.pop_front());
                  if (exp_req && imem_ack) begin
                     m_q.push_back(ent_t'({imem_rdata, nxt}));
                     m_pc   = nxt;
                     m_pend = 1'b0;
                  end else begin
                     m_pend = exp_req;
                  end
               end
            end
            M_DROP: begin
               if (imem_ack) m_pend = 1'b0;
               if (halt) begin
                  m_mode = M_HALT;
                  if (pop) void'(m_q.pop_front());
               end else begin
                  if (redirect_valid) begin
                     m_pc = redirect_addr;
                     m_q.delete();
                  end else if (pop) void'(m_q.pop_front());
                  if (imem_ack) m_mode = M_FETCH;
               end
            end
            default: begin
               if (pop) void'(m_q.pop_front());
               if (imem_ack) m_pend = 1'b0;
            end
         endcase
      end
      if (mem_busy) begin
         if (imem_ack) mem_busy = 1'b0;
         else mem_cnt++;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0; redirect_valid = 1'b0; halt = 1'b0;
      prep();
      adv();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; out_ready = 1'b1; mem_lat = 1;
      prep();
      n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      adv();
      rst = 1'b1;
      prep();
      n_checks++; if (imem_req !== 1'b1) begin n_errors++; $display("FAIL reset_exit_req: got %b want 1", imem_req); end
      n_checks++; if (imem_addr !== RESET_PC) begin n_errors++; $display("FAIL reset_exit_addr: got %h want %h", imem_addr, RESET_PC); end
      adv();
   endtask

   task automatic test_comb_stream();
      logic [15:0] addrs[$], pcns[$], instrs[$];
      logic [15:0] got;
      mem_lat = 1; mem_key = 16'hA5A5; out_ready = 1'b1;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         prep();
         if (imem_req) addrs.push_back(imem_addr);
         if (out_valid) begin pcns.push_back(out_pc_next); instrs.push_back(out_instr); end
         if (c >= 1) begin
            n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL stream_rate cycle %0d: got %b want 1", c, out_valid); end
         end
         adv();
      end
      for (int i = 0; i < 4; i++) begin
         got = (i < addrs.size()) ? addrs[i] : 16'hxxxx;
         n_checks++; if (got !== 16'(2*i)) begin n_errors++; $display("FAIL stream_addr[%0d]: got %h want %h", i, got, 16'(2*i)); end
         got = (i < pcns.size()) ? pcns[i] : 16'hxxxx;
         n_checks++; if (got !== 16'(2*i+2)) begin n_errors++; $display("FAIL stream_pc_next[%0d]: got %h want %h", i, got, 16'(2*i+2)); end
         got = (i < instrs.size()) ? instrs[i] : 16'hxxxx;
         n_checks++; if (got !== (16'(2*i) ^ 16'hA5A5)) begin n_errors++; $display("FAIL stream_instr[%0d]: got %h want %h", i, got, 16'(2*i) ^ 16'hA5A5); end
      end
   endtask

   task automatic test_latency_backpressure();
      int          n_push;
      bit          seen;
      logic [15:0] first_addr, got;
      logic [15:0] pcns[$];
      mem_lat = 3; mem_key = 16'hA5A5; out_ready = 1'b0; n_push = 0; seen = 1'b0; first_addr = 'x;
      do_reset();
      for (int c = 0; c < 24; c++) begin
         prep();
         if (imem_req && imem_ack) n_push++;
         adv();
      end
      n_checks++; if (n_push != 4) begin n_errors++; $display("FAIL bp_push_count: got %0d want 4", n_push); end
      prep();
      n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL bp_full_req: got %b want 0", imem_req); end
      n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_full_valid: got %b want 1", out_valid); end
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL bp_full_busy: got %b want 1", busy); end
      adv();
      out_ready = 1'b1;
      for (int c = 0; c < 30; c++) begin
         prep();
         if (out_valid) pcns.push_back(out_pc_next);
         if (imem_req && !seen) begin seen = 1'b1; first_addr = imem_addr; end
         adv();
      end
      for (int i = 0; i < 4; i++) begin
         got = (i < pcns.size()) ? pcns[i] : 16'hxxxx;
         n_checks++; if (got !== 16'(2*i+2)) begin n_errors++; $display("FAIL bp_drain[%0d]: got %h want %h", i, got, 16'(2*i+2)); end
      end
      n_checks++; if (first_addr !== 16'h0008) begin n_errors++; $display("FAIL bp_resume_addr: got %h want 0008", first_addr); end
   endtask

   task automatic test_redirect_drop();
      bit          found, seen, got_v;
      logic [15:0] first_addr, first_pcn, first_instr;
      mem_lat = 3; mem_key = 16'h5A3C; out_ready = 1'b0;
      found = 1'b0; seen = 1'b0; got_v = 1'b0;
      first_addr = 'x; first_pcn = 'x; first_instr = 'x;
      do_reset();
      for (int c = 0; c < 40 && !found; c++) begin
         prep();
         if (imem_req && !imem_ack && imem_addr == 16'h0006) begin
            found = 1'b1; redirect_valid = 1'b1; redirect_addr = 16'h0100;
         end
         adv();
         redirect_valid = 1'b0;
      end
      n_checks++; if (!found) begin n_errors++; $display("FAIL drop_setup: got no request to 0006 want one within 40 cycles"); end
      prep();
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL drop_flush: got out_valid %b want 0", out_valid); end
      n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL drop_req: got %b want 0", imem_req); end
      adv();
      out_ready = 1'b1;
      for (int c = 0; c < 30; c++) begin
         prep();
         if (imem_req && !seen) begin seen = 1'b1; first_addr = imem_addr; end
         if (out_valid && !got_v) begin got_v = 1'b1; first_pcn = out_pc_next; first_instr = out_instr; end
         adv();
      end
      n_checks++; if (first_addr !== 16'h0100) begin n_errors++; $display("FAIL drop_next_addr: got %h want 0100", first_addr); end
      n_checks++; if (first_pcn !== 16'h0102) begin n_errors++; $display("FAIL drop_pc_next: got %h want 0102", first_pcn); end
      n_checks++; if (first_instr !== (16'h0100 ^ 16'h5A3C)) begin n_errors++; $display("FAIL drop_instr: got %h want %h", first_instr, 16'h0100 ^ 16'h5A3C); end
   endtask

   task automatic test_redirect_ack();
      bit          found, got, leaked;
      logic [15:0] stale, first_pcn;
      mem_lat = 3; mem_key = 16'h1234; out_ready = 1'b1;
      found = 1'b0; got = 1'b0; leaked = 1'b0; stale = 'x; first_pcn = 'x;
      do_reset();
      for (int c = 0; c < 20 && !found; c++) begin
         prep();
         if (imem_ack) begin
            found = 1'b1; stale = imem_rdata; redirect_valid = 1'b1; redirect_addr = 16'h0200;
         end
         adv();
         redirect_valid = 1'b0;
      end
      n_checks++; if (!found) begin n_errors++; $display("FAIL redir_ack_setup: got no ack want one within 20 cycles"); end
      prep();
      n_checks++; if (imem_req !== 1'b1) begin n_errors++; $display("FAIL redir_ack_req: got %b want 1", imem_req); end
      n_checks++; if (imem_addr !== 16'h0200) begin n_errors++; $display("FAIL redir_ack_addr: got %h want 0200", imem_addr); end
      adv();
      for (int c = 0; c < 20; c++) begin
         prep();
         if (out_valid) begin
            if (!got) first_pcn = out_pc_next;
            got = 1'b1;
            if (out_instr === stale) leaked = 1'b1;
         end
         adv();
      end
      n_checks++; if (leaked) begin n_errors++; $display("FAIL redir_ack_leak: got stale instr %h on output want never", stale); end
      n_checks++; if (first_pcn !== 16'h0202) begin n_errors++; $display("FAIL redir_ack_pc_next: got %h want 0202", first_pcn); end
   endtask

   task automatic test_halt();
      bit          found;
      int          acks, pops, req_cycles;
      logic [15:0] pcns[$];
      logic [15:0] got;
      mem_lat = 3; mem_key = 16'h0F0F; out_ready = 1'b0;
      found = 1'b0; acks = 0; pops = 0; req_cycles = 0;
      do_reset();
      for (int c = 0; c < 40 && !found; c++) begin
         prep();
         if (acks == 2 && imem_req && !imem_ack) begin
            found = 1'b1; halt = 1'b1; redirect_valid = 1'b1; redirect_addr = 16'h0300;
         end
         if (imem_req && imem_ack) acks++;
         adv();
         halt = 1'b0; redirect_valid = 1'b0;
      end
      n_checks++; if (!found) begin n_errors++; $display("FAIL halt_setup: got %0d acks want 2 then pending request", acks); end
      out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         prep();
         if (imem_req) req_cycles++;
         if (out_valid) begin pops++; pcns.push_back(out_pc_next); end
         adv();
      end
      prep();
      n_checks++; if (req_cycles != 0) begin n_errors++; $display("FAIL halt_req: got %0d request cycles want 0", req_cycles); end
      n_checks++; if (pops != 2) begin n_errors++; $display("FAIL halt_drain_count: got %0d want 2", pops); end
      for (int i = 0; i < 2; i++) begin
         got = (i < pcns.size()) ? pcns[i] : 16'hxxxx;
         n_checks++; if (got !== 16'(2*i+2)) begin n_errors++; $display("FAIL halt_drain[%0d]: got %h want %h", i, got, 16'(2*i+2)); end
      end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL halt_busy: got %b want 0", busy); end
      adv();
   endtask

   task automatic test_wrap_reset();
      mem_lat = 1; mem_key = 16'h7777; out_ready = 1'b1;
      do_reset();
      prep();
      redirect_valid = 1'b1; redirect_addr = 16'hFFFE;
      adv();
      redirect_valid = 1'b0;
      prep();
      n_checks++; if (imem_addr !== 16'hFFFE) begin n_errors++; $display("FAIL wrap_start_addr: got %h want fffe", imem_addr); end
      adv();
      prep();
      n_checks++; if (imem_addr !== 16'h0000) begin n_errors++; $display("FAIL wrap_addr: got %h want 0000", imem_addr); end
      n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL wrap_valid: got %b want 1", out_valid); end
      n_checks++; if (out_pc_next !== 16'h0000) begin n_errors++; $display("FAIL wrap_pc_next: got %h want 0000", out_pc_next); end
      n_checks++; if (out_instr !== (16'hFFFE ^ 16'h7777)) begin n_errors++; $display("FAIL wrap_instr: got %h want %h", out_instr, 16'hFFFE ^ 16'h7777); end
      adv();
      prep();
      adv();
      mem_lat = 3;
      prep();
      adv();
      rst = 1'b0;
      prep();
      n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL midreset_req: got %b want 0", imem_req); end
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL midreset_valid: got %b want 0", out_valid); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
      adv();
      rst = 1'b1;
      prep();
      n_checks++; if (imem_req !== 1'b1) begin n_errors++; $display("FAIL postreset_req: got %b want 1", imem_req); end
      n_checks++; if (imem_addr !== RESET_PC) begin n_errors++; $display("FAIL postreset_addr: got %h want %h", imem_addr, RESET_PC); end
      adv();
   endtask

   task automatic test_random();
      mem_key = 16'($urandom);
      do_reset();
      for (int c = 0; c < 800; c++) begin
         if (!mem_busy) mem_lat = $urandom_range(1, 4);
         out_ready      = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 15) == 0);
         redirect_addr  = 16'($urandom) & 16'hFFFE;
         halt           = ($urandom_range(0, 199) == 0);
         rst            = (m_mode == M_HALT) ? ($urandom_range(0, 19) != 0)
                                             : ($urandom_range(0, 299) != 0);
         prep();
         n_checks++; if (imem_req !== exp_req) begin n_errors++; $display("FAIL rand_req cycle %0d: got %b want %b", c, imem_req, exp_req); end
         if (exp_req) begin
            n_checks++; if (imem_addr !== m_pc) begin n_errors++; $display("FAIL rand_addr cycle %0d: got %h want %h", c, imem_addr, m_pc); end
         end
         n_checks++; if (out_valid !== exp_valid) begin n_errors++; $display("FAIL rand_valid cycle %0d: got %b want %b", c, out_valid, exp_valid); end
         if (exp_valid) begin
            n_checks++; if (out_instr !== exp_head.instr) begin n_errors++; $display("FAIL rand_instr cycle %0d: got %h want %h", c, out_instr, exp_head.instr); end
            n_checks++; if (out_pc_next !== exp_head.pc_next) begin n_errors++; $display("FAIL rand_pc_next cycle %0d: got %h want %h", c, out_pc_next, exp_head.pc_next); end
         end
         n_checks++; if (busy !== exp_busy) begin n_errors++; $display("FAIL rand_busy cycle %0d: got %b want %b", c, busy, exp_busy); end
         adv();
      end
      rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b0; imem_ack = 1'b0; imem_rdata = '0; redirect_valid = 1'b0; redirect_addr = '0;
      halt = 1'b0; out_ready = 1'b0;
      mem_lat = 1; mem_busy = 1'b0; mem_cnt = 0; mem_addr = '0; mem_key = 16'hA5A5;
      m_pc = RESET_PC; m_mode = M_FETCH; m_pend = 1'b0;
      @(negedge clk);
      test_reset();
      test_comb_stream();
      test_latency_backpressure();
      test_redirect_drop();
      test_redirect_ack();
      test_halt();
      test_wrap_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
